// File: rtl/flag_branch_unit_pkg.sv
// Shared types for the flag/branch path: NZCV flag layout, ARM condition codes,
// branch kinds and resolve-FSM states.
package flag_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    typedef enum logic [1:0] {
        BR_B    = 2'b00,
        BR_COND = 2'b01,
        BR_CBZ  = 2'b10,
        BR_CBNZ = 2'b11
    } br_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    localparam nzcv_t NZCV_RESET = 4'b0000;

endpackage

// File: rtl/flag_branch_unit_if.sv
// EX-stage flag/branch bundle between the pipeline (master) and flag_branch_unit (slave).
interface flag_branch_unit_if;
    logic       ex_valid;
    logic       ex_set_flags;
    logic       alu_negative;
    logic       alu_zero;
    logic       alu_overflow;
    logic       alu_carry_out;
    logic       br_valid;
    logic [1:0] br_type;
    logic [3:0] br_cond;
    logic       br_reg_zero;
    logic       stall;
    logic       flush;
    logic [3:0] nzcv;
    logic       br_taken;
    logic       br_done;
    logic       flag_hazard;

    modport master (
        output ex_valid, ex_set_flags, alu_negative, alu_zero, alu_overflow,
               alu_carry_out, br_valid, br_type, br_cond, br_reg_zero, stall, flush,
        input  nzcv, br_taken, br_done, flag_hazard
    );

    modport slave (
        input  ex_valid, ex_set_flags, alu_negative, alu_zero, alu_overflow,
               alu_carry_out, br_valid, br_type, br_cond, br_reg_zero, stall, flush,
        output nzcv, br_taken, br_done, flag_hazard
    );
endinterface

// File: rtl/flag_branch_unit_cond_eval.sv
// Pure combinational ARM condition evaluator; shared with the conditional-select unit.
module cond_eval
    import flag_pkg::*;
(
    input  cond_e cond_i,
    input  nzcv_t flags_i,
    output logic  taken_o
);

    always_comb begin
        taken_o = 1'b1;
        case (cond_i)
            COND_EQ: taken_o =  flags_i.z;
            COND_NE: taken_o = !flags_i.z;
            COND_CS: taken_o =  flags_i.c;
            COND_CC: taken_o = !flags_i.c;
            COND_MI: taken_o =  flags_i.n;
            COND_PL: taken_o = !flags_i.n;
            COND_VS: taken_o =  flags_i.v;
            COND_VC: taken_o = !flags_i.v;
            COND_HI: taken_o =  (flags_i.c & !flags_i.z);
            COND_LS: taken_o = !(flags_i.c & !flags_i.z);
            COND_GE: taken_o =  (flags_i.n == flags_i.v);
            COND_LT: taken_o =  (flags_i.n != flags_i.v);
            COND_GT: taken_o =  (!flags_i.z & (flags_i.n == flags_i.v));
            COND_LE: taken_o = !(!flags_i.z & (flags_i.n == flags_i.v));
            default: taken_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// NZCV flag register and branch resolver feeding the PC-select mux.
// Optional live-flag forwarding is compiled in with `define FLAG_BRANCH_FWD_EN.
module flag_branch_unit
    import flag_pkg::*;
(
    input logic                clk,
    input logic                rst_n,
    flag_branch_unit_if.slave  bus
);

    nzcv_t  flags_q, flags_d;
    nzcv_t  alu_flags, eff_flags;
    logic   taken_q, taken_d;
    state_e state_q, state_d;
    logic   cond_taken, decision, hazard, flag_wr, br_fire;

    assign alu_flags = '{n: bus.alu_negative, z: bus.alu_zero,
                         c: bus.alu_carry_out, v: bus.alu_overflow};
    assign flag_wr   = bus.ex_valid & bus.ex_set_flags & !bus.stall & !bus.flush;

`ifdef FLAG_BRANCH_FWD_EN
    // The branch is younger than the EX instruction, so it must see that instruction's flags.
    assign eff_flags = (bus.ex_valid & bus.ex_set_flags) ? alu_flags : flags_q;
    assign hazard    = 1'b0;
`else
    assign eff_flags = flags_q;
    assign hazard    = bus.br_valid & (bus.br_type == BR_COND) & bus.ex_valid
                     & bus.ex_set_flags & !bus.flush;
`endif

    cond_eval u_cond_eval (
        .cond_i  (cond_e'(bus.br_cond)),
        .flags_i (eff_flags),
        .taken_o (cond_taken)
    );

    always_comb begin
        decision = 1'b1;
        case (br_type_e'(bus.br_type))
            BR_B:    decision = 1'b1;
            BR_COND: decision = cond_taken;
            BR_CBZ:  decision = bus.br_reg_zero;
            BR_CBNZ: decision = !bus.br_reg_zero;
            default: decision = 1'b1;
        endcase
    end

    assign br_fire = bus.br_valid & !bus.stall & !bus.flush & !hazard;

    // DONE lasts one cycle unless another qualifying branch lands right behind it.
    always_comb begin
        flags_d = flag_wr ? alu_flags : flags_q;
        taken_d = br_fire ? decision : taken_q;
        state_d = br_fire ? ST_DONE : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= NZCV_RESET;
            taken_q <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            flags_q <= flags_d;
            taken_q <= taken_d;
            state_q <= state_d;
        end
    end

    assign bus.nzcv        = flags_q;
    assign bus.br_taken    = taken_q;
    assign bus.br_done     = (state_q == ST_DONE);
    assign bus.flag_hazard = hazard;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: vector table, condition sweep and
// hand-written hazard/stall/flush/reset sequences with a branch-result scoreboard.
module tb_flag_branch_unit;
    import flag_pkg::*;

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       taken;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   testsRun = 0;
    int   testsFailed = 0;
    logic expQ[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    flag_branch_unit_if bus ();

    flag_branch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Independent reference: base condition from cond[3:1], cond[0] inverts except AL/NV.
    function automatic logic refCond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c[0] && (c[3:1] != 3'd7)) r = !r;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        bus.ex_valid = 0; bus.ex_set_flags = 0;
        bus.alu_negative = 0; bus.alu_zero = 0; bus.alu_carry_out = 0; bus.alu_overflow = 0;
        bus.br_valid = 0; bus.br_type = 2'b00; bus.br_cond = 4'h0; bus.br_reg_zero = 0;
        bus.stall = 0; bus.flush = 0;
    endtask

    // alu is {N,Z,C,V}; expectFire pushes the expected br_taken onto the scoreboard.
    task automatic applyStimulus(input logic bv, input logic [1:0] bt, input logic [3:0] cond,
                                 input logic rz, input logic exv, input logic setf,
                                 input logic [3:0] alu, input logic st, input logic fl,
                                 input logic expectFire, input logic expTaken);
        bus.br_valid = bv; bus.br_type = bt; bus.br_cond = cond; bus.br_reg_zero = rz;
        bus.ex_valid = exv; bus.ex_set_flags = setf;
        bus.alu_negative = alu[3]; bus.alu_zero = alu[2];
        bus.alu_carry_out = alu[1]; bus.alu_overflow = alu[0];
        bus.stall = st; bus.flush = fl;
        if (expectFire) expQ.push_back(expTaken);
    endtask

    task automatic tick(input string tag);
        logic e;
        logic pending;
        @(posedge clk);
        #1;
        pending = (expQ.size() != 0);
        checkOutput({tag, "/br_done"}, {3'b0, bus.br_done}, {3'b0, pending});
        if (pending) begin
            e = expQ.pop_front();
            if (bus.br_done) checkOutput({tag, "/br_taken"}, {3'b0, bus.br_taken}, {3'b0, e});
        end
    endtask

    task automatic loadFlags(input logic [3:0] f, input string tag);
        applyStimulus(0, BR_B, 4'h0, 0, 1, 1, f, 0, 0, 0, 0);
        tick(tag);
        checkOutput({tag, "/nzcv"}, bus.nzcv, f);
        idleInputs();
    endtask

    initial begin
        vecs[0]  = '{4'b0110, COND_EQ, 1'b1};
        vecs[1]  = '{4'b0110, COND_NE, 1'b0};
        vecs[2]  = '{4'b1000, COND_GE, 1'b0};
        vecs[3]  = '{4'b1000, COND_LT, 1'b1};
        vecs[4]  = '{4'b1001, COND_GT, 1'b1};
        vecs[5]  = '{4'b1001, COND_LE, 1'b0};
        vecs[6]  = '{4'b0010, COND_HI, 1'b1};
        vecs[7]  = '{4'b0110, COND_LS, 1'b1};
        vecs[8]  = '{4'b0000, COND_CC, 1'b1};
        vecs[9]  = '{4'b0000, COND_MI, 1'b0};
        vecs[10] = '{4'b0000, COND_AL, 1'b1};
        vecs[11] = '{4'b0000, COND_NV, 1'b1};

        idleInputs();
        rst_n = 1'b0;
        #2;
        checkOutput("reset/nzcv", bus.nzcv, 4'h0);
        checkOutput("reset/br_done", {3'b0, bus.br_done}, 4'h0);
        checkOutput("reset/br_taken", {3'b0, bus.br_taken}, 4'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // SUBS 5-5 then EQ and NE back to back.
        loadFlags(4'b0110, "subs");
        applyStimulus(1, BR_COND, COND_EQ, 0, 0, 0, 4'h0, 0, 0, 1, 1);
        tick("beq");
        applyStimulus(1, BR_COND, COND_NE, 0, 0, 0, 4'h0, 0, 0, 1, 0);
        tick("bne");
        idleInputs();
        tick("idle");

        foreach (vecs[i]) begin
            loadFlags(vecs[i].flags, $sformatf("vec%0d_ld", i));
            applyStimulus(1, BR_COND, vecs[i].cond, 0, 0, 0, 4'h0, 0, 0, 1, vecs[i].taken);
            tick($sformatf("vec%0d", i));
            idleInputs();
        end

        // Full sweep; each flag value drives 16 consecutive B.cond resolutions.
        for (int f = 0; f < 16; f++) begin
            loadFlags(4'(f), $sformatf("sw%0d_ld", f));
            for (int c = 0; c < 16; c++) begin
                applyStimulus(1, BR_COND, 4'(c), 0, 0, 0, 4'h0, 0, 0, 1, refCond(4'(c), 4'(f)));
                tick($sformatf("sw_f%0d_c%0d", f, c));
            end
            idleInputs();
        end

        // Same-cycle ADDS (V=1) and B.cond VS with nzcv=0000.
        loadFlags(4'b0000, "fwd_ld");
`ifdef FLAG_BRANCH_FWD_EN
        applyStimulus(1, BR_COND, COND_VS, 0, 1, 1, 4'b0001, 0, 0, 1, 1);
        #1;
        checkOutput("fwd/flag_hazard", {3'b0, bus.flag_hazard}, 4'h0);
`else
        applyStimulus(1, BR_COND, COND_VS, 0, 1, 1, 4'b0001, 0, 0, 0, 0);
        #1;
        checkOutput("haz/flag_hazard", {3'b0, bus.flag_hazard}, 4'h1);
`endif
        tick("haz_t");
        checkOutput("haz/nzcv", bus.nzcv, 4'b0001);
        applyStimulus(1, BR_COND, COND_VS, 0, 0, 0, 4'h0, 0, 0, 1, 1);
        #1;
        checkOutput("haz_re/flag_hazard", {3'b0, bus.flag_hazard}, 4'h0);
        tick("haz_re");
        idleInputs();

        // CBZ alongside a flag-setting EX never raises a hazard.
        applyStimulus(1, BR_CBZ, 4'h0, 1, 1, 1, 4'b0101, 0, 0, 1, 1);
        #1;
        checkOutput("cbz/flag_hazard", {3'b0, bus.flag_hazard}, 4'h0);
        tick("cbz");
        checkOutput("cbz/nzcv", bus.nzcv, 4'b0101);

        // Stall and flush must leave flags and branch state untouched.
        applyStimulus(0, BR_B, 4'h0, 0, 1, 1, 4'b1010, 1, 0, 0, 0);
        tick("stall_adds");
        checkOutput("stall_adds/nzcv", bus.nzcv, 4'b0101);
        applyStimulus(0, BR_B, 4'h0, 0, 1, 1, 4'b1010, 0, 1, 0, 0);
        tick("flush_adds");
        checkOutput("flush_adds/nzcv", bus.nzcv, 4'b0101);
        applyStimulus(1, BR_COND, COND_AL, 0, 0, 0, 4'h0, 0, 1, 0, 0);
        tick("flush_br");
        applyStimulus(1, BR_B, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0, 0);
        tick("stall_br");
        checkOutput("stall_br/br_taken", {3'b0, bus.br_taken}, 4'h1);
        applyStimulus(1, BR_CBZ, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
        tick("cbz_nt");
        idleInputs();

        // Reset while DONE with nzcv=1111.
        loadFlags(4'b1111, "rst_ld");
        applyStimulus(1, BR_B, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 1);
        tick("rst_br");
        idleInputs();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid/nzcv", bus.nzcv, 4'h0);
        checkOutput("rst_mid/br_done", {3'b0, bus.br_done}, 4'h0);
        checkOutput("rst_mid/br_taken", {3'b0, bus.br_taken}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, BR_CBNZ, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 1);
        tick("cbnz");
        idleInputs();
        tick("end_idle");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
